obstacle_draw_pipe: RTL

Per-pixel renderer that consumes the level-selected object table: 8 rectangles, each with position, size, colour and enable. For the current VGA pixel it decides whether any enabled object covers that pixel, and outputs a drawing request and RGB332 colour 2 cycles later. It also keeps a per-frame sticky record of which objects overlapped the player sprite, for use by game logic.

---
 rtl/obstacle_draw_pipe.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/obstacle_draw_pipe.sv
// Two-stage per-pixel renderer for the 8-entry obstacle table, with per-frame
// sticky player-overlap flags and a pulse on each newly hit object.
module obstacle_draw_pipe #(
    parameter int         NUM_OBJ           = 8,
    parameter int         COORD_W           = 11,
    parameter logic [7:0] TRANSPARENT_COLOR = 8'hFF
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic [COORD_W-1:0]         pixelX,
    input  logic [COORD_W-1:0]         pixelY,
    input  logic                       pixelValid,
    input  logic                       startOfFrame,
    input  logic                       playerDrawingRequest,
    input  logic [NUM_OBJ*COORD_W-1:0] topLeftX,
    input  logic [NUM_OBJ*COORD_W-1:0] topLeftY,
    input  logic [NUM_OBJ*COORD_W-1:0] width,
    input  logic [NUM_OBJ*COORD_W-1:0] height,
    input  logic [NUM_OBJ*8-1:0]       color,
    input  logic [NUM_OBJ-1:0]         enable,
    output logic                       drawingRequest,
    output logic [7:0]                 RGBout,
    output logic [NUM_OBJ-1:0]         hitFlags,
    output logic                       collisionPulse,
    output logic [2:0]                 hitIndex
);

    // Edge sums carry one extra bit so objects touching the right/bottom edge never wrap.
    function automatic logic obj_covers(
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py,
        input logic [COORD_W-1:0] ox,
        input logic [COORD_W-1:0] oy,
        input logic [COORD_W-1:0] ow,
        input logic [COORD_W-1:0] oh
    );
        logic [COORD_W:0] x_end;
        logic [COORD_W:0] y_end;
        x_end = {1'b0, ox} + {1'b0, ow};
        y_end = {1'b0, oy} + {1'b0, oh};
        return (px >= ox) && ({1'b0, px} < x_end) &&
               (py >= oy) && ({1'b0, py} < y_end);
    endfunction

    function automatic logic [2:0] lowest_index(input logic [NUM_OBJ-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[2:0];
            end
        end
        return idx;
    endfunction

    logic [NUM_OBJ-1:0]   cover_s;
    logic [NUM_OBJ-1:0]   cover_r1;
    logic [NUM_OBJ*8-1:0] color_r1;
    logic                 player_r1;
    logic [2:0]           win_idx_s;
    logic [7:0]           rgb_s;
    logic [NUM_OBJ-1:0]   new_hits_s;
    logic                 draw_req_r;
    logic [7:0]           rgb_r;
    logic [NUM_OBJ-1:0]   hit_flags_r;
    logic                 coll_pulse_r;
    logic [2:0]           hit_idx_r;

    // Per-object coverage test for the incoming pixel.
    always_comb begin
        cover_s = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            cover_s[i] = enable[i] &&
                         (color[i*8 +: 8] != TRANSPARENT_COLOR) &&
                         obj_covers(pixelX, pixelY,
                                    topLeftX[i*COORD_W +: COORD_W],
                                    topLeftY[i*COORD_W +: COORD_W],
                                    width[i*COORD_W +: COORD_W],
                                    height[i*COORD_W +: COORD_W]);
        end
    end

    // Stage 1: capture coverage, colours and player overlap; table is not looked at again.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cover_r1  <= '0;
            color_r1  <= '0;
            player_r1 <= 1'b0;
        end else begin
            cover_r1  <= cover_s & {NUM_OBJ{pixelValid}};
            color_r1  <= color;
            player_r1 <= playerDrawingRequest & pixelValid;
        end
    end

    // Stage 2 combinational: fixed-priority winner and collision detection.
    always_comb begin
        win_idx_s  = lowest_index(cover_r1);
        new_hits_s = cover_r1 & {NUM_OBJ{player_r1}} & ~hit_flags_r;
        if (|cover_r1) begin
            rgb_s = color_r1[{win_idx_s, 3'b000} +: 8];
        end else begin
            rgb_s = 8'h00;
        end
    end

    // Stage 2 registers: drawing outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            draw_req_r <= 1'b0;
            rgb_r      <= 8'h00;
        end else begin
            draw_req_r <= |cover_r1;
            rgb_r      <= rgb_s;
        end
    end

    // Frame-sticky hit flags; a frame start wins over any hit arriving with it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_flags_r  <= '0;
            coll_pulse_r <= 1'b0;
            hit_idx_r    <= 3'd0;
        end else if (startOfFrame) begin
            hit_flags_r  <= '0;
            coll_pulse_r <= 1'b0;
            hit_idx_r    <= hit_idx_r;
        end else begin
            hit_flags_r  <= hit_flags_r | new_hits_s;
            coll_pulse_r <= |new_hits_s;
            if (|new_hits_s) begin
                hit_idx_r <= lowest_index(new_hits_s);
            end else begin
                hit_idx_r <= hit_idx_r;
            end
        end
    end

    assign drawingRequest = draw_req_r;
    assign RGBout         = rgb_r;
    assign hitFlags       = hit_flags_r;
    assign collisionPulse = coll_pulse_r;
    assign hitIndex       = hit_idx_r;

endmodule
